// File: rtl/gtx_tx_align_inserter.sv
// gtx_tx_align_inserter
//
// Builds the word stream for a 16-bit GTX transmitter. It merges link-layer dwords with
// periodic ALIGNP bursts and fills with SYNCP dwords when the link layer has nothing to send.
// Exactly one word leaves every wclk. Dword phase alternates low/high every cycle after reset.
//
// Parameters
//   ALIGN_PERIOD  DATA/FILL dwords emitted between ALIGNP bursts
//   ALIGN_BURST   ALIGNP primitives per burst (>= 1)
//   CNT_W         dword counter width (ALIGN_PERIOD must fit)
//
// Ports
//   wclk          clock; all logic on its rising edge
//   rst           synchronous, active-low reset
//   in_data       link-layer word (low word of a dword first)
//   in_charisk    K-flags for in_data bytes
//   in_valid      in_data/in_charisk valid
//   in_ready      next output slot takes an input word (from registered state only)
//   force_align   request continuous ALIGNP, sampled at dword boundaries
//   tx_data       registered word to GTX TXDATA
//   tx_charisk    registered word to GTX TXCHARISK
//   lword_strobe  tx_data holds the high (second) word of a dword
//   align_busy    tx_data holds an ALIGNP word
//   underrun      sticky: in_valid was low in a high-word DATA slot
module gtx_tx_align_inserter #(
  parameter int unsigned ALIGN_PERIOD = 254,
  parameter int unsigned ALIGN_BURST  = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        wclk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_charisk,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        force_align,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_charisk,
  output logic        lword_strobe,
  output logic        align_busy,
  output logic        underrun
);

  localparam int unsigned BURST_W = $clog2(ALIGN_BURST + 1);

  localparam logic [15:0] AlignLo = 16'h4ABC;
  localparam logic [15:0] AlignHi = 16'h7B4A;
  localparam logic [15:0] SyncLo  = 16'h957C;
  localparam logic [15:0] SyncHi  = 16'hB5B5;
  localparam logic [1:0]  KLo     = 2'b01;
  localparam logic [1:0]  KHi     = 2'b00;

  localparam logic [CNT_W-1:0]   PeriodMax = CNT_W'(ALIGN_PERIOD);
  localparam logic [BURST_W-1:0] BurstLast = BURST_W'(ALIGN_BURST - 1);

  // State of the dword whose next word is about to be emitted.
  typedef enum logic [1:0] {
    StAlign,
    StData,
    StFill
  } state_e;

  state_e             state_q, state_d;
  logic               hi_q, hi_d;          // next emitted word is the high word
  logic [CNT_W-1:0]   cnt_q, cnt_d;        // completed DATA/FILL dwords since last burst
  logic [BURST_W-1:0] burst_q, burst_d;    // ALIGNPs completed in the current burst
  logic               ext_q, ext_d;        // ALIGNP in flight was started under force_align
  logic [15:0]        tx_data_q, tx_data_d;
  logic [1:0]         tx_charisk_q, tx_charisk_d;
  logic               lword_q, lword_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;
  logic [CNT_W-1:0]   cnt_inc;

  always_ff @(posedge wclk) begin
    if (!rst) begin
      state_q      <= StAlign;
      hi_q         <= 1'b0;
      cnt_q        <= '0;
      burst_q      <= '0;
      ext_q        <= 1'b0;
      tx_data_q    <= AlignLo;
      tx_charisk_q <= KLo;
      lword_q      <= 1'b0;
      busy_q       <= 1'b1;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      cnt_q        <= cnt_d;
      burst_q      <= burst_d;
      ext_q        <= ext_d;
      tx_data_q    <= tx_data_d;
      tx_charisk_q <= tx_charisk_d;
      lword_q      <= lword_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hi_d         = ~hi_q;
    cnt_d        = cnt_q;
    burst_d      = burst_q;
    ext_d        = ext_q;
    tx_data_d    = AlignLo;
    tx_charisk_d = KLo;
    lword_d      = hi_q;
    busy_d       = 1'b0;
    underrun_d   = underrun_q;
    cnt_inc      = cnt_q + 1'b1;

    // Word selection for the slot being emitted at this edge.
    unique case (state_q)
      StAlign: begin
        busy_d       = 1'b1;
        tx_data_d    = hi_q ? AlignHi : AlignLo;
        tx_charisk_d = hi_q ? KHi : KLo;
      end
      StData: begin
        if (in_valid) begin
          tx_data_d    = in_data;
          tx_charisk_d = in_charisk;
        end else if (!hi_q) begin
          // Nothing at the start of a dword: the whole dword becomes SYNCP.
          tx_data_d    = SyncLo;
          tx_charisk_d = KLo;
          state_d      = StFill;
        end else begin
          // Half a dword already sent: pad the high word and flag it.
          tx_data_d    = SyncHi;
          tx_charisk_d = KHi;
          underrun_d   = 1'b1;
        end
      end
      StFill: begin
        tx_data_d    = hi_q ? SyncHi : SyncLo;
        tx_charisk_d = hi_q ? KHi : KLo;
      end
      default: begin
        tx_data_d    = AlignLo;
        tx_charisk_d = KLo;
        state_d      = StAlign;
      end
    endcase

    // Dword boundary: decide what the next dword is.
    if (hi_q) begin
      if (state_q == StAlign) begin
        if (force_align) begin
          ext_d   = 1'b1;
          burst_d = '0;
        end else if (ext_q) begin
          // Last ALIGNP started under force; it does not count toward the tail burst.
          ext_d   = 1'b0;
          burst_d = '0;
        end else if (burst_q == BurstLast) begin
          state_d = StData;
          cnt_d   = '0;
          burst_d = '0;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_inc;
        if (force_align) begin
          state_d = StAlign;
          ext_d   = 1'b1;
          burst_d = '0;
        end else if (cnt_inc == PeriodMax) begin
          state_d = StAlign;
          burst_d = '0;
        end else begin
          state_d = StData;
        end
      end
    end
  end

  assign in_ready     = (state_q == StData);
  assign tx_data      = tx_data_q;
  assign tx_charisk   = tx_charisk_q;
  assign lword_strobe = lword_q;
  assign align_busy   = busy_q;
  assign underrun     = underrun_q;

endmodule
